// File: rtl/wt_mult_pkg.sv
// wt_mult_pkg: shared helpers for the pipelined Wallace-tree multiplier.
//   prod_w      - product width for a W-bit operand pair
//   rows_after  - rows left after one 3:2 carry-save level
//   rows_at     - rows present at a given tree level (level 0 = W pp rows + correction row)
//   csa_levels  - number of CSA levels needed to reach two rows
//   bw_corr     - Baugh-Wooley correction constant (bits W and 2W-1)
//   cla_add     - parallel-prefix carry-lookahead adder, MAX_PW bits
package wt_mult_pkg;

  localparam int MAX_W  = 32;
  localparam int MAX_PW = 2 * MAX_W;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int rows_after(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int rows_at(input int w, input int lvl);
    int n;
    n = w + 1;
    for (int unsigned i = 0; i < lvl; i++) n = rows_after(n);
    return n;
  endfunction

  // Reduction from n rows only reaches 2 via a level with exactly 3 rows,
  // so the last level is always a single CSA.
  function automatic int csa_levels(input int w);
    int n;
    int l;
    n = w + 1;
    l = 0;
    while (n > 2) begin
      n = rows_after(n);
      l++;
    end
    return l;
  endfunction

  function automatic logic [MAX_PW-1:0] bw_corr(input int w);
    logic [MAX_PW-1:0] c;
    c = '0;
    c[w]       = 1'b1;
    c[2*w - 1] = 1'b1;
    return c;
  endfunction

  // Kogge-Stone prefix carry computation; callers truncate to their width.
  function automatic logic [MAX_PW-1:0] cla_add(input logic [MAX_PW-1:0] x,
                                                input logic [MAX_PW-1:0] y);
    logic [MAX_PW-1:0] p;
    logic [MAX_PW-1:0] gg;
    logic [MAX_PW-1:0] pp;
    p  = x ^ y;
    gg = x & y;
    pp = p;
    for (int unsigned d = 1; d < MAX_PW; d = d * 2) begin
      gg = gg | (pp & (gg << d));
      pp = pp & (pp << d);
    end
    return p ^ (gg << 1);
  endfunction

endpackage

// File: rtl/wt_mult_pipe_csa_row.sv
// csa_row: N-bit 3:2 carry-save row.
//   x, y, z - three addend vectors
//   sum     - bitwise sum (x ^ y ^ z)
//   carry   - bitwise majority, unshifted (weight is one position higher)
module csa_row #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/wt_mult_pipe.sv
// wt_mult_pipe: two-stage pipelined W x W Wallace-tree multiplier with
// per-beat signed/unsigned mode and valid/ready flow control.
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - operand handshake
//   a, b, is_signed      - operands and mode (two's complement when is_signed)
//   out_valid/out_ready  - product handshake
//   product              - full-precision product, PROD_W bits
// Stage 1: partial products + CSA tree -> sum/carry registers.
// Stage 2: carry-lookahead add -> product register.
module wt_mult_pipe
  import wt_mult_pkg::*;
#(
  parameter int W      = 8,
  parameter int PROD_W = prod_w(W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic              is_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  localparam int NR  = W + 1;
  localparam int LEV = csa_levels(W);
  localparam logic [PROD_W-1:0] BW_CORR = PROD_W'(bw_corr(W));

  logic              s1_valid;
  logic              s2_valid;
  logic              s1_ready;
  logic              s2_ready;
  logic [PROD_W-1:0] s1_sum;
  logic [PROD_W-1:0] s1_carry;
  logic [PROD_W-1:0] fin_sum;
  logic [PROD_W-1:0] fin_carry;

  logic [PROD_W-1:0] pp  [NR];
  logic [PROD_W-1:0] lvl [LEV][NR];

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  // Baugh-Wooley: in signed mode the MSB row/column terms (but not the
  // MSB*MSB term) are inverted; the extra row carries the correction.
  always_comb begin
    for (int unsigned i = 0; i < W; i++) begin
      pp[i] = '0;
      for (int unsigned j = 0; j < W; j++)
        pp[i][i+j] = (a[j] & b[i]) ^ (is_signed && ((i == W - 1) != (j == W - 1)));
    end
    pp[W] = is_signed ? BW_CORR : '0;
  end

  for (genvar r = 0; r < NR; r++) begin : g_lvl0
    assign lvl[0][r] = pp[r];
  end

  for (genvar l = 0; l < LEV - 1; l++) begin : g_lvl
    localparam int N = rows_at(W, l);
    localparam int G = N / 3;
    for (genvar g = 0; g < G; g++) begin : g_csa
      logic [PROD_W-1:0] s;
      logic [PROD_W-1:0] c;
      csa_row #(.N(PROD_W)) u_csa (
        .x(lvl[l][3*g]), .y(lvl[l][3*g+1]), .z(lvl[l][3*g+2]),
        .sum(s), .carry(c)
      );
      assign lvl[l+1][2*g]   = s;
      assign lvl[l+1][2*g+1] = c << 1;
    end
    for (genvar r = 3 * G; r < N; r++) begin : g_pass
      assign lvl[l+1][2*G + r - 3*G] = lvl[l][r];
    end
    for (genvar r = rows_after(N); r < NR; r++) begin : g_fill
      assign lvl[l+1][r] = '0;
    end
  end

  // Last level always holds exactly three rows; its carry is registered
  // unshifted and aligned in stage 2.
  csa_row #(.N(PROD_W)) u_csa_last (
    .x(lvl[LEV-1][0]), .y(lvl[LEV-1][1]), .z(lvl[LEV-1][2]),
    .sum(fin_sum), .carry(fin_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_sum   <= '0;
      s1_carry <= '0;
      product  <= '0;
    end else begin
      if (s1_ready) s1_valid <= in_valid;
      if (in_valid && s1_ready) begin
        s1_sum   <= fin_sum;
        s1_carry <= fin_carry;
      end
      if (s2_ready) s2_valid <= s1_valid;
      if (s1_valid && s2_ready)
        product <= PROD_W'(cla_add(MAX_PW'(s1_sum), MAX_PW'(s1_carry << 1)));
    end
  end

endmodule

// File: tb/tb_wt_mult_pipe.sv
module tb_wt_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv  [3];
  logic        sv  [3];
  logic        orv [3];
  logic [31:0] av  [3];
  logic [31:0] bv  [3];

  logic        ir4, ov4, ir8, ov8, ir16, ov16;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wt_mult_pipe #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir4), .a(av[0][3:0]), .b(bv[0][3:0]),
    .is_signed(sv[0]), .out_valid(ov4), .out_ready(orv[0]), .product(p4)
  );
  wt_mult_pipe #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir8), .a(av[1][7:0]), .b(bv[1][7:0]),
    .is_signed(sv[1]), .out_valid(ov8), .out_ready(orv[1]), .product(p8)
  );
  wt_mult_pipe #(.W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir16), .a(av[2][15:0]), .b(bv[2][15:0]),
    .is_signed(sv[2]), .out_valid(ov16), .out_ready(orv[2]), .product(p16)
  );

  function automatic logic get_ov(input int unsigned s);
    case (s)
      0:       return ov4;
      1:       return ov8;
      default: return ov16;
    endcase
  endfunction

  function automatic logic get_ir(input int unsigned s);
    case (s)
      0:       return ir4;
      1:       return ir8;
      default: return ir16;
    endcase
  endfunction

  function automatic longint unsigned get_p(input int unsigned s);
    case (s)
      0:       return longint'(p4);
      1:       return longint'(p8);
      default: return longint'(p16);
    endcase
  endfunction

  // Reference: interpret operands per mode, multiply exactly, keep 2w bits.
  function automatic longint unsigned ref_prod(input int unsigned w, input longint unsigned x,
                                               input longint unsigned y, input logic s);
    longint sx, sy;
    longint unsigned m;
    m = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    if (s) begin
      sx = $signed(x << (64 - w)) >>> (64 - w);
      sy = $signed(y << (64 - w)) >>> (64 - w);
    end else begin
      sx = longint'(x);
      sy = longint'(y);
    end
    return longint'(sx * sy) & m;
  endfunction

  function automatic longint unsigned pick(input int unsigned w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(7, 0))
      0:       return 64'd0;
      1:       return m;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; sv[i] = 1'b0; orv[i] = 1'b1; av[i] = '0; bv[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ov8 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", ov8); end
    n_cmp++;
    if (p8 !== 16'h0) begin n_err++; $display("FAIL reset_product: got %h expected 0000", p8); end
    n_cmp++;
    if (ir8 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", ir8); end
    n_cmp++;
    if ({ov4, ov16} !== 2'b00) begin n_err++; $display("FAIL reset_other_valid: got %b expected 00", {ov4, ov16}); end
  endtask

  task automatic test_unsigned();
    logic [7:0]  ta [2] = '{8'd255, 8'd0};
    logic [7:0]  tb [2] = '{8'd255, 8'd200};
    logic [15:0] te [2] = '{16'hFE01, 16'h0000};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      iv[1] = 1'b1; av[1] = 32'(ta[k]); bv[1] = 32'(tb[k]); sv[1] = 1'b0; orv[1] = 1'b1;
      @(negedge clk);
      iv[1] = 1'b0;
      #1;
      n_cmp++;
      if (ov8 !== 1'b0) begin n_err++; $display("FAIL unsigned_early_%0d: got out_valid %b expected 0", k, ov8); end
      @(negedge clk);
      #1;
      n_cmp++;
      if (ov8 !== 1'b1 || p8 !== te[k])
        begin n_err++; $display("FAIL unsigned_%0d: got v=%b p=%h expected v=1 p=%h", k, ov8, p8, te[k]); end
    end
  endtask

  task automatic test_signed();
    logic [7:0]  ta [4] = '{8'h80, 8'hFF, 8'h80, 8'h05};
    logic [7:0]  tb [4] = '{8'h80, 8'h7F, 8'h7F, 8'hFD};
    logic [15:0] te [4] = '{16'h4000, 16'hFF81, 16'hC080, 16'hFFF1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      iv[1] = 1'b1; av[1] = 32'(ta[k]); bv[1] = 32'(tb[k]); sv[1] = 1'b1; orv[1] = 1'b1;
      @(negedge clk);
      iv[1] = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if (ov8 !== 1'b1 || p8 !== te[k])
        begin n_err++; $display("FAIL signed_%0d: got v=%b p=%h expected v=1 p=%h", k, ov8, p8, te[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    orv[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (k >= 2) begin
        e = ((k - 2) % 2 == 1) ? 16'hFFFE : 16'h01FE;
        n_cmp++;
        if (ov8 !== 1'b1 || p8 !== e)
          begin n_err++; $display("FAIL b2b_%0d: got v=%b p=%h expected v=1 p=%h", k - 2, ov8, p8, e); end
      end
      if (k < 6) begin
        iv[1] = 1'b1; av[1] = 32'h0FF; bv[1] = 32'h002; sv[1] = 1'(k % 2);
      end else begin
        iv[1] = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  ta [3] = '{8'd3, 8'd5, 8'd7};
    logic [7:0]  tb [3] = '{8'd4, 8'd6, 8'd8};
    logic [15:0] te [3] = '{16'd12, 16'd30, 16'd56};
    int sent = 0;
    int got  = 0;
    @(negedge clk);
    orv[1] = 1'b0; sv[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      iv[1] = 1'b1; av[1] = 32'(ta[sent]); bv[1] = 32'(tb[sent]);
      #1;
      if (c >= 2) begin
        n_cmp++;
        if (ir8 !== 1'b0) begin n_err++; $display("FAIL bp_full_%0d: got in_ready %b expected 0", c, ir8); end
        n_cmp++;
        if (ov8 !== 1'b1 || p8 !== 16'd12)
          begin n_err++; $display("FAIL bp_stable_%0d: got v=%b p=%0d expected v=1 p=12", c, ov8, p8); end
      end
      if (ir8) sent++;
      @(negedge clk);
    end
    n_cmp++;
    if (sent != 2) begin n_err++; $display("FAIL bp_accepted: got %0d expected 2", sent); end
    orv[1] = 1'b1;
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (sent < 3) begin iv[1] = 1'b1; av[1] = 32'(ta[sent]); bv[1] = 32'(tb[sent]); end
      else iv[1] = 1'b0;
      #1;
      if (iv[1] && ir8) sent++;
      if (ov8) begin
        n_cmp++;
        if (p8 !== te[got]) begin n_err++; $display("FAIL bp_out_%0d: got %0d expected %0d", got, p8, te[got]); end
        got++;
      end
      @(negedge clk);
    end
    iv[1] = 1'b0;
    n_cmp++;
    if (got != 3) begin n_err++; $display("FAIL bp_drain_count: got %0d expected 3", got); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    orv[1] = 1'b0; sv[1] = 1'b0;
    iv[1] = 1'b1; av[1] = 32'd9; bv[1] = 32'd9;
    @(negedge clk);
    av[1] = 32'd3; bv[1] = 32'd3;
    @(negedge clk);
    iv[1] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ov8 !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b expected 0", ov8); end
    @(negedge clk);
    rst = 1'b0; orv[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (ov8 !== 1'b0) begin n_err++; $display("FAIL rst_stale_%0d: got out_valid %b expected 0", c, ov8); end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (ir8 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", ir8); end
    iv[1] = 1'b1; av[1] = 32'd6; bv[1] = 32'd7;
    @(negedge clk);
    iv[1] = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (ov8 !== 1'b1 || p8 !== 16'd42)
      begin n_err++; $display("FAIL rst_recover: got v=%b p=%0d expected v=1 p=42", ov8, p8); end
  endtask

  task automatic test_random(input int unsigned sel, input int unsigned w, input int unsigned beats);
    longint unsigned q[$];
    longint unsigned e;
    int unsigned sent = 0;
    int unsigned got  = 0;
    int unsigned cyc  = 0;
    @(negedge clk);
    while (got < beats && cyc < beats * 10) begin
      iv[sel]  = (sent < beats) && ($urandom_range(3, 0) != 0);
      av[sel]  = 32'(pick(w));
      bv[sel]  = 32'(pick(w));
      sv[sel]  = 1'($urandom_range(1, 0));
      orv[sel] = ($urandom_range(3, 0) != 0);
      #1;
      if (iv[sel] && get_ir(sel)) begin
        q.push_back(ref_prod(w, longint'(av[sel]), longint'(bv[sel]), sv[sel]));
        sent++;
      end
      if (get_ov(sel) && orv[sel]) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_w%0d_extra: got product %h with no beat outstanding", w, get_p(sel));
        end else begin
          e = q.pop_front();
          if (get_p(sel) !== e)
            begin n_err++; $display("FAIL rand_w%0d_beat%0d: got %h expected %h", w, got, get_p(sel), e); end
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    iv[sel] = 1'b0; orv[sel] = 1'b1;
    n_cmp++;
    if (got != beats || q.size() != 0)
      begin n_err++; $display("FAIL rand_w%0d_count: got %0d outputs, %0d pending, expected %0d, 0", w, got, q.size(), beats); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random(1, 8, 10000);
    test_random(0, 4, 3000);
    test_random(2, 16, 3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
